// File: rtl/conv_enc_sched_if.sv
// Descriptor, encoder control/FIFO and output byte-stream signals of the encoder block scheduler.
// The scheduler uses the master modport; the surrounding stages use the slave modport.
interface conv_enc_sched_if;
   logic       desc_valid;
   logic       desc_size;
   logic [7:0] desc_tail;
   logic       desc_ready;
   logic       enc_blk_ready;
   logic       enc_code_block_length;
   logic [7:0] enc_tail_byte;
   logic       enc_computation_done;
   logic       enc_rdreq_subblock;
   logic [7:0] enc_q0;
   logic [7:0] enc_q1;
   logic [7:0] enc_q2;
   logic       out_valid;
   logic [7:0] out_data;
   logic [1:0] out_stream;
   logic       out_last;
   logic       out_ready;

   modport master (
      input  desc_valid, desc_size, desc_tail, enc_computation_done,
             enc_q0, enc_q1, enc_q2, out_ready,
      output desc_ready, enc_blk_ready, enc_code_block_length, enc_tail_byte,
             enc_rdreq_subblock, out_valid, out_data, out_stream, out_last
   );

   modport slave (
      output desc_valid, desc_size, desc_tail, enc_computation_done,
             enc_q0, enc_q1, enc_q2, out_ready,
      input  desc_ready, enc_blk_ready, enc_code_block_length, enc_tail_byte,
             enc_rdreq_subblock, out_valid, out_data, out_stream, out_last
   );
endinterface

// File: rtl/conv_enc_sched.sv
// Block scheduler for the three-output convolutional encoder: launches one code block, waits
// for completion, then drains the three output FIFOs in lock-step onto one byte stream.
module conv_enc_sched #(
   parameter int SMALL_BYTES  = 132,
   parameter int LARGE_BYTES  = 768,
   parameter int START_GUARD  = 4,
   parameter int DONE_TIMEOUT = 16384
) (
   input  logic             clk,
   input  logic             reset,
   conv_enc_sched_if.master bus,
   output logic             busy,
   output logic [15:0]      blk_count,
   output logic             err_timeout
);
   localparam int GW = $clog2(DONE_TIMEOUT + 1);
   localparam logic [9:0]    N_SMALL   = 10'(SMALL_BYTES);
   localparam logic [9:0]    N_LARGE   = 10'(LARGE_BYTES);
   localparam logic [GW-1:0] GUARD_END = GW'(START_GUARD);
   localparam logic [GW-1:0] TMO_LAST  = GW'(DONE_TIMEOUT - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LAUNCH = 3'd1;
   localparam logic [2:0] ST_ENCODE = 3'd2;
   localparam logic [2:0] ST_RD     = 3'd3;
   localparam logic [2:0] ST_CAP    = 3'd4;
   localparam logic [2:0] ST_EMIT0  = 3'd5;
   localparam logic [2:0] ST_EMIT1  = 3'd6;
   localparam logic [2:0] ST_EMIT2  = 3'd7;

   logic [2:0]    state_r, state_s;
   logic [GW-1:0] guard_r, guard_s;
   logic [9:0]    trip_r, trip_s;
   logic [9:0]    target_r, target_s;
   logic [23:0]   hold_r, hold_s;
   logic          size_r, size_s;
   logic [7:0]    tail_r, tail_s;
   logic [15:0]   blk_count_r, blk_count_s;
   logic          err_r, err_s;

   logic          desc_ready_r, blk_ready_r, rdreq_r, busy_r;
   logic          out_valid_r, out_valid_s;
   logic [7:0]    out_data_r, out_data_s;
   logic [1:0]    out_stream_r, out_stream_s;
   logic          out_last_r, out_last_s;

   logic          handshake_s, emit_ack_s;

   assign handshake_s = bus.desc_valid & desc_ready_r;
   assign emit_ack_s  = out_valid_r & bus.out_ready;

   // Next-state and datapath update for the block sequencing FSM
   always_comb begin
      state_s     = state_r;
      guard_s     = guard_r;
      trip_s      = trip_r;
      target_s    = target_r;
      hold_s      = hold_r;
      size_s      = size_r;
      tail_s      = tail_r;
      blk_count_s = blk_count_r;
      err_s       = err_r;
      case (state_r)
         ST_IDLE: begin
            if (handshake_s) begin
               size_s   = bus.desc_size;
               tail_s   = bus.desc_tail;
               target_s = bus.desc_size ? N_LARGE : N_SMALL;
               trip_s   = 10'd0;
               state_s  = ST_LAUNCH;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            guard_s = {GW{1'b0}};
            state_s = ST_ENCODE;
         end
         ST_ENCODE: begin
            // done is only trusted once the encoder has had START_GUARD cycles to drop its old flag
            if ((guard_r >= GUARD_END) && bus.enc_computation_done) begin
               state_s = ST_RD;
            end else if (guard_r == TMO_LAST) begin
               err_s   = 1'b1;
               state_s = ST_IDLE;
            end else begin
               guard_s = guard_r + GW'(1);
            end
         end
         ST_RD: begin
            state_s = ST_CAP;
         end
         ST_CAP: begin
            hold_s  = {bus.enc_q2, bus.enc_q1, bus.enc_q0};
            trip_s  = trip_r + 10'd1;
            state_s = ST_EMIT0;
         end
         ST_EMIT0: begin
            if (emit_ack_s) begin
               state_s = ST_EMIT1;
            end else begin
               state_s = ST_EMIT0;
            end
         end
         ST_EMIT1: begin
            if (emit_ack_s) begin
               state_s = ST_EMIT2;
            end else begin
               state_s = ST_EMIT1;
            end
         end
         ST_EMIT2: begin
            if (emit_ack_s && (trip_r == target_r)) begin
               blk_count_s = blk_count_r + 16'd1;
               state_s     = ST_IDLE;
            end else if (emit_ack_s) begin
               state_s     = ST_RD;
            end else begin
               state_s     = ST_EMIT2;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Output-stream values for the coming cycle, decoded from the next state so outputs are registered
   always_comb begin
      out_valid_s  = 1'b0;
      out_data_s   = 8'd0;
      out_stream_s = 2'd0;
      out_last_s   = 1'b0;
      case (state_s)
         ST_EMIT0: begin
            out_valid_s  = 1'b1;
            out_data_s   = hold_s[7:0];
            out_stream_s = 2'd0;
         end
         ST_EMIT1: begin
            out_valid_s  = 1'b1;
            out_data_s   = hold_s[15:8];
            out_stream_s = 2'd1;
         end
         ST_EMIT2: begin
            out_valid_s  = 1'b1;
            out_data_s   = hold_s[23:16];
            out_stream_s = 2'd2;
            out_last_s   = (trip_s == target_s);
         end
         default: begin
            out_valid_s  = 1'b0;
         end
      endcase
   end

   // State, datapath and registered outputs with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         guard_r      <= {GW{1'b0}};
         trip_r       <= 10'd0;
         target_r     <= 10'd0;
         hold_r       <= 24'd0;
         size_r       <= 1'b0;
         tail_r       <= 8'd0;
         blk_count_r  <= 16'd0;
         err_r        <= 1'b0;
         desc_ready_r <= 1'b1;
         blk_ready_r  <= 1'b0;
         rdreq_r      <= 1'b0;
         busy_r       <= 1'b0;
         out_valid_r  <= 1'b0;
         out_data_r   <= 8'd0;
         out_stream_r <= 2'd0;
         out_last_r   <= 1'b0;
      end else begin
         state_r      <= state_s;
         guard_r      <= guard_s;
         trip_r       <= trip_s;
         target_r     <= target_s;
         hold_r       <= hold_s;
         size_r       <= size_s;
         tail_r       <= tail_s;
         blk_count_r  <= blk_count_s;
         err_r        <= err_s;
         desc_ready_r <= (state_s == ST_IDLE);
         blk_ready_r  <= (state_s == ST_LAUNCH);
         rdreq_r      <= (state_s == ST_RD);
         busy_r       <= (state_s != ST_IDLE);
         out_valid_r  <= out_valid_s;
         out_data_r   <= out_data_s;
         out_stream_r <= out_stream_s;
         out_last_r   <= out_last_s;
      end
   end

   assign bus.desc_ready            = desc_ready_r;
   assign bus.enc_blk_ready         = blk_ready_r;
   assign bus.enc_code_block_length = size_r;
   assign bus.enc_tail_byte         = tail_r;
   assign bus.enc_rdreq_subblock    = rdreq_r;
   assign bus.out_valid             = out_valid_r;
   assign bus.out_data              = out_data_r;
   assign bus.out_stream            = out_stream_r;
   assign bus.out_last              = out_last_r;
   assign busy                      = busy_r;
   assign blk_count                 = blk_count_r;
   assign err_timeout               = err_r;
endmodule

// File: tb/tb_conv_enc_sched.sv
// Self-checking bench for conv_enc_sched: random FIFO contents and backpressure compared against
// a queue-based model of the expected byte stream plus cycle arithmetic for launch/drain timing.
module tb_conv_enc_sched;
   localparam int SMALL = 132;
   localparam int LARGE = 768;
   localparam int GUARD = 4;
   localparam int TMO   = 64;

   typedef struct {
      logic       size;
      logic [7:0] tail;
      int         done_from;
      int         glitch;
   } desc_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        busy;
   logic [15:0] blk_count;
   logic        err_timeout;

   conv_enc_sched_if bus ();

   conv_enc_sched #(
      .SMALL_BYTES (SMALL),
      .LARGE_BYTES (LARGE),
      .START_GUARD (GUARD),
      .DONE_TIMEOUT(TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .busy       (busy),
      .blk_count  (blk_count),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   logic [7:0] mem0 [8192];
   logic [7:0] mem1 [8192];
   logic [7:0] mem2 [8192];
   int         rd_ptr = 0;

   // Encoder output FIFOs: data appears the cycle after a read request
   always @(posedge clk) begin
      if (bus.enc_rdreq_subblock) begin
         bus.enc_q0 <= mem0[rd_ptr];
         bus.enc_q1 <= mem1[rd_ptr];
         bus.enc_q2 <= mem2[rd_ptr];
         rd_ptr     <= rd_ptr + 1;
      end
   end

   int checks = 0, failures = 0;
   int cyc = 0, ecnt = 0, nbytes = 0, n_rd = 0, n_launch = 0, n_last = 0, last_idx = 0;
   int last_cyc = -100, first_rd_cyc = 0, first_rd_ecnt = -1, accept_cyc = -100, accept_gap = 0;
   int exp_ptr = 0, exp_blk = 0, err_ecnt = -1, stall_n = 0;
   bit in_enc = 1'b0, err_seen = 1'b0, bp = 1'b0, stalled = 1'b0;
   logic [10:0] prev_b;
   desc_t       pend_q[$];
   desc_t       cur_d;
   logic [10:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic accept_desc();
      int n;
      cur_d      = pend_q.pop_front();
      accept_gap = cyc - last_cyc;
      accept_cyc = cyc;
      // a block whose done never arrives is aborted by timeout and yields no bytes
      if (cur_d.done_from >= 0) begin
         n = cur_d.size ? LARGE : SMALL;
         for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, 2'd0, mem0[exp_ptr + i]});
            exp_q.push_back({1'b0, 2'd1, mem1[exp_ptr + i]});
            exp_q.push_back({(i == n - 1), 2'd2, mem2[exp_ptr + i]});
         end
         exp_ptr += n;
         exp_blk++;
      end
   endtask

   task automatic tick();
      logic [10:0] got_b, exp_b;
      @(negedge clk);
      cyc++;
      if (stalled) begin
         stall_n++;
         chk("stall_hold",
             32'({bus.out_valid, bus.out_last, bus.out_stream, bus.out_data, bus.enc_rdreq_subblock}),
             32'({1'b1, prev_b, 1'b0}));
      end
      if (bus.enc_blk_ready) begin
         n_launch++;
         ecnt   = 0;
         in_enc = 1'b1;
         chk("launch_latency", 32'(cyc - accept_cyc), 32'd1);
         chk("launch_len", 32'(bus.enc_code_block_length), 32'(cur_d.size));
         chk("launch_tail", 32'(bus.enc_tail_byte), 32'(cur_d.tail));
      end else if (in_enc) begin
         ecnt++;
      end
      if (bus.enc_rdreq_subblock) begin
         n_rd++;
         if (in_enc) begin
            first_rd_ecnt = ecnt;
            first_rd_cyc  = cyc;
            in_enc        = 1'b0;
         end
      end
      if (err_timeout && !err_seen) begin
         err_seen = 1'b1;
         err_ecnt = ecnt;
      end
      if (in_enc && bus.desc_ready) in_enc = 1'b0;
      bus.enc_computation_done = in_enc &&
         (((cur_d.done_from >= 0) && (ecnt >= cur_d.done_from)) || (ecnt == cur_d.glitch));
      bus.out_ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
      got_b = {bus.out_last, bus.out_stream, bus.out_data};
      if (bus.out_valid && bus.out_ready) begin
         nbytes++;
         exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
         chk("byte", 32'(got_b), 32'(exp_b));
         if (bus.out_last) begin
            n_last++;
            last_idx = nbytes;
            last_cyc = cyc;
         end
      end
      stalled = bus.out_valid && !bus.out_ready;
      prev_b  = got_b;
      if (pend_q.size() > 0) begin
         bus.desc_valid = 1'b1;
         bus.desc_size  = pend_q[0].size;
         bus.desc_tail  = pend_q[0].tail;
         if (bus.desc_ready) accept_desc();
      end else begin
         bus.desc_valid = 1'b0;
         bus.desc_size  = 1'($urandom);
         bus.desc_tail  = 8'($urandom);
      end
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!((pend_q.size() == 0) && (exp_q.size() == 0) && bus.desc_ready && !in_enc &&
                   (cyc >= accept_cyc + 2)) && (n < budget));
      chk(tag, 32'(n < budget), 32'd1);
   endtask

   task automatic clear_counts();
      nbytes = 0; n_rd = 0; n_launch = 0; n_last = 0; last_idx = 0; stall_n = 0;
   endtask

   initial begin
      int n;
      for (int i = 0; i < 8192; i++) begin
         mem0[i] = 8'($urandom);
         mem1[i] = 8'($urandom);
         mem2[i] = 8'($urandom);
      end
      reset = 1'b0;
      bus.desc_valid = 1'b0;
      bus.desc_size = 1'b0;
      bus.desc_tail = 8'd0;
      bus.enc_computation_done = 1'b0;
      bus.out_ready = 1'b1;
      cur_d = '{1'b0, 8'd0, -1, -1};
      tick();
      tick();
      chk("rst_ctrl", 32'({bus.enc_blk_ready, bus.enc_rdreq_subblock, bus.out_valid, bus.out_last,
                           busy, err_timeout}), 32'd0);
      chk("rst_data", 32'({bus.out_data, bus.out_stream, bus.enc_code_block_length,
                           bus.enc_tail_byte}), 32'd0);
      chk("rst_blk_count", 32'(blk_count), 32'd0);
      reset = 1'b1;
      tick();
      chk("rst_desc_ready", 32'(bus.desc_ready), 32'd1);

      // small block, done glitch on the last guarded cycle, real done from ENCODE cycle 12
      clear_counts();
      pend_q.push_back('{1'b0, 8'hA5, 13, GUARD});
      wait_idle("s1_complete", 2000);
      chk("s1_launches", 32'(n_launch), 32'd1);
      chk("s1_rdreq", 32'(n_rd), 32'd132);
      chk("s1_bytes", 32'(nbytes), 32'd396);
      chk("s1_last_pos", 32'(last_idx), 32'd396);
      chk("s1_last_cnt", 32'(n_last), 32'd1);
      chk("s1_done_to_rd", 32'(first_rd_ecnt), 32'd14);
      chk("s1_drain_cycles", 32'(last_cyc - first_rd_cyc + 1), 32'd660);
      chk("s1_blk_count", 32'(blk_count), 32'(exp_blk));
      chk("s1_tail_hold", 32'(bus.enc_tail_byte), 32'hA5);

      // large block, done already high before the guard expires
      clear_counts();
      pend_q.push_back('{1'b1, 8'($urandom), 0, -1});
      wait_idle("s2_complete", 5000);
      chk("s2_rdreq", 32'(n_rd), 32'd768);
      chk("s2_bytes", 32'(nbytes), 32'd2304);
      chk("s2_last_pos", 32'(last_idx), 32'd2304);
      chk("s2_guard_exit", 32'(first_rd_ecnt), 32'(GUARD + 2));
      chk("s2_drain_cycles", 32'(last_cyc - first_rd_cyc + 1), 32'd3840);
      chk("s2_len_hold", 32'(bus.enc_code_block_length), 32'd1);
      chk("s2_blk_count", 32'(blk_count), 32'(exp_blk));

      // small block under random 30% out_ready
      clear_counts();
      bp = 1'b1;
      pend_q.push_back('{1'b0, 8'($urandom), 8, -1});
      wait_idle("s3_complete", 5000);
      bp = 1'b0;
      chk("s3_rdreq", 32'(n_rd), 32'd132);
      chk("s3_bytes", 32'(nbytes), 32'd396);
      chk("s3_last_pos", 32'(last_idx), 32'd396);
      chk("s3_saw_stalls", 32'(stall_n > 0), 32'd1);
      chk("s3_blk_count", 32'(blk_count), 32'(exp_blk));

      // back-to-back small then large with desc_valid held
      clear_counts();
      pend_q.push_back('{1'b0, 8'($urandom), 6, -1});
      pend_q.push_back('{1'b1, 8'($urandom), 6, -1});
      wait_idle("s4_complete", 7000);
      chk("s4_bytes", 32'(nbytes), 32'd2700);
      chk("s4_rdreq", 32'(n_rd), 32'd900);
      chk("s4_launches", 32'(n_launch), 32'd2);
      chk("s4_accept_gap", 32'(accept_gap), 32'd1);
      chk("s4_blk_count", 32'(blk_count), 32'(exp_blk));

      // encoder never finishes
      clear_counts();
      pend_q.push_back('{1'b0, 8'($urandom), -1, -1});
      wait_idle("s5_complete", 300);
      chk("s5_err", 32'(err_timeout), 32'd1);
      chk("s5_err_cycle", 32'(err_ecnt), 32'(TMO + 1));
      chk("s5_rdreq", 32'(n_rd), 32'd0);
      chk("s5_launches", 32'(n_launch), 32'd1);
      chk("s5_blk_count", 32'(blk_count), 32'(exp_blk));
      chk("s5_idle", 32'({bus.desc_ready, busy}), 32'b10);

      // reset in the middle of draining a block
      clear_counts();
      pend_q.push_back('{1'b0, 8'($urandom), 6, -1});
      n = 0;
      while ((nbytes < 50) && (n < 1000)) begin
         tick();
         n++;
      end
      chk("s6_reach_50", 32'(nbytes >= 50), 32'd1);
      reset = 1'b0;
      exp_q.delete();
      pend_q.delete();
      tick();
      in_enc = 1'b0;
      stalled = 1'b0;
      chk("s6_rst_state", 32'({bus.out_valid, busy, bus.enc_rdreq_subblock, bus.desc_ready,
                               err_timeout}), 32'b00010);
      chk("s6_rst_blk_count", 32'(blk_count), 32'd0);
      reset = 1'b1;
      exp_ptr = rd_ptr;
      exp_blk = 0;
      clear_counts();
      pend_q.push_back('{1'b0, 8'($urandom), 10, -1});
      wait_idle("s6_complete", 2000);
      chk("s6_bytes", 32'(nbytes), 32'd396);
      chk("s6_rdreq", 32'(n_rd), 32'd132);
      chk("s6_last_pos", 32'(last_idx), 32'd396);
      chk("s6_blk_count", 32'(blk_count), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
